imem_loader: RTL and testbench

//  Writer side of the byte-addressed instruction memory: accepts 32-bit instruction words over a

---
 rtl/imem_loader_pkg.sv | 20 ++
 rtl/imem_byte_serializer.sv | 42 ++++
 rtl/imem_loader.sv | 149 ++++++++++++++
 tb/tb_imem_loader.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader and the memory it feeds.
package imem_loader_pkg;

   localparam int unsigned MEM_BYTES_DEFAULT = 128;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_CHECK     = 3'd1,
      ST_WAIT_WORD = 3'd2,
      ST_WRITE     = 3'd3,
      ST_FINISH    = 3'd4,
      ST_FAIL      = 3'd5
   } state_e;

   // Little-endian byte lane select: idx 0 is bits [7:0].
   function automatic logic [7:0] word_byte(input logic [31:0] word, input logic [1:0] idx);
      return word[{idx, 3'b000} +: 8];
   endfunction

endpackage

// File: rtl/imem_byte_serializer.sv
// Holds one 32-bit word and presents its bytes LSB-first, one per advance.
// byte_o is registered and returns to zero on clear.
module imem_byte_serializer
   import imem_loader_pkg::*;
(
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        load_i,
   input  logic        next_i,
   input  logic        clear_i,
   input  logic [31:0] word_i,
   output logic [7:0]  byte_o,
   output logic        last_o
);

   logic [31:0] word_q;
   logic [1:0]  idx_q;
   logic [7:0]  byte_q;

   // Load presents byte 0 immediately; each advance steps to the next lane.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         word_q <= '0;
         idx_q  <= '0;
         byte_q <= '0;
      end else if (clear_i) begin
         idx_q  <= '0;
         byte_q <= '0;
      end else if (load_i) begin
         word_q <= word_i;
         idx_q  <= '0;
         byte_q <= word_byte(word_i, 2'd0);
      end else if (next_i) begin
         idx_q  <= idx_q + 2'd1;
         byte_q <= word_byte(word_q, idx_q + 2'd1);
      end
   end

   assign byte_o = byte_q;
   assign last_o = (idx_q == 2'd3);

endmodule

// File: rtl/imem_loader.sv
// Writes a stream of 32-bit instruction words into a byte-addressed memory,
// little-endian, one byte per cycle, after bounds-checking the request.
module imem_loader
   import imem_loader_pkg::*;
#(
   parameter int unsigned MEM_BYTES = MEM_BYTES_DEFAULT,
   parameter int unsigned ADDR_W    = 64,
   parameter int unsigned CNT_W     = 6
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [CNT_W-1:0]  word_count,
   input  logic              in_valid,
   input  logic [31:0]       in_data,
   output logic              in_ready,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [7:0]        mem_wdata,
   output logic              busy,
   output logic              done,
   output logic              error
);

   state_e              state_q;
   logic [ADDR_W-1:0]   cur_addr_q;
   logic [CNT_W-1:0]    words_left_q;
   logic                in_ready_q;
   logic                mem_we_q;
   logic [ADDR_W-1:0]   mem_addr_q;
   logic                busy_q;
   logic                done_q;
   logic                error_q;

   logic                ser_load;
   logic                ser_next;
   logic                ser_clear;
   logic                ser_last;
   logic [7:0]          ser_byte;
   logic [ADDR_W:0]     end_addr;
   logic                out_of_range;

   // One extra bit keeps base + 4*count from wrapping.
   always_comb begin
      end_addr     = {1'b0, cur_addr_q} + ({{(ADDR_W + 1 - CNT_W){1'b0}}, words_left_q} << 2);
      out_of_range = end_addr > (ADDR_W + 1)'(MEM_BYTES);
   end

   assign ser_load  = (state_q == ST_WAIT_WORD) && in_valid && in_ready_q;
   assign ser_next  = (state_q == ST_WRITE) && !ser_last;
   assign ser_clear = (state_q == ST_WRITE) && ser_last;

   imem_byte_serializer u_ser (
      .clk_i   (clk),
      .rst_ni  (rst_n),
      .load_i  (ser_load),
      .next_i  (ser_next),
      .clear_i (ser_clear),
      .word_i  (in_data),
      .byte_o  (ser_byte),
      .last_o  (ser_last)
   );

   // Load FSM; cur_addr_q/words_left_q double as the latched base and count.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         cur_addr_q   <= '0;
         words_left_q <= '0;
         in_ready_q   <= 1'b0;
         mem_we_q     <= 1'b0;
         mem_addr_q   <= '0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         error_q      <= 1'b0;
      end else begin
         done_q  <= 1'b0;
         error_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (start) begin
                  cur_addr_q   <= base_addr;
                  words_left_q <= word_count;
                  busy_q       <= 1'b1;
                  state_q      <= ST_CHECK;
               end
            end
            ST_CHECK: begin
               if (cur_addr_q[1:0] != 2'b00) begin
                  error_q <= 1'b1;
                  state_q <= ST_FAIL;
               end else if (out_of_range) begin
                  error_q <= 1'b1;
                  state_q <= ST_FAIL;
               end else if (words_left_q == '0) begin
                  done_q  <= 1'b1;
                  state_q <= ST_FINISH;
               end else begin
                  in_ready_q <= 1'b1;
                  state_q    <= ST_WAIT_WORD;
               end
            end
            ST_WAIT_WORD: begin
               if (in_valid && in_ready_q) begin
                  in_ready_q <= 1'b0;
                  mem_we_q   <= 1'b1;
                  mem_addr_q <= cur_addr_q;
                  cur_addr_q <= cur_addr_q + ADDR_W'(1);
                  state_q    <= ST_WRITE;
               end
            end
            ST_WRITE: begin
               if (!ser_last) begin
                  mem_addr_q <= cur_addr_q;
                  cur_addr_q <= cur_addr_q + ADDR_W'(1);
               end else begin
                  mem_we_q     <= 1'b0;
                  words_left_q <= words_left_q - CNT_W'(1);
                  if (words_left_q == CNT_W'(1)) begin
                     done_q  <= 1'b1;
                     state_q <= ST_FINISH;
                  end else begin
                     in_ready_q <= 1'b1;
                     state_q    <= ST_WAIT_WORD;
                  end
               end
            end
            ST_FINISH, ST_FAIL: begin
               busy_q  <= 1'b0;
               state_q <= ST_IDLE;
            end
            default: begin
               busy_q  <= 1'b0;
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign in_ready  = in_ready_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = ser_byte;
   assign busy      = busy_q;
   assign done      = done_q;
   assign error     = error_q;

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: stimulus pushes expected byte writes and
// completion events; a negedge monitor pops and compares them.
module tb_imem_loader;

   localparam int unsigned MEMB = 128;

   typedef struct {
      logic [63:0] a;
      logic [7:0]  d;
   } wr_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [63:0] base_addr = '0;
   logic [5:0]  word_count = '0;
   logic        in_valid = 1'b0;
   logic [31:0] in_data = '0;
   logic        in_ready;
   logic        mem_we;
   logic [63:0] mem_addr;
   logic [7:0]  mem_wdata;
   logic        busy;
   logic        done;
   logic        error;

   int          total = 0;
   int          bad = 0;
   bit          mon_en = 1'b0;
   bit          prev_we = 1'b0;
   wr_t         exp_q[$];
   int          ev_q[$];       // 1: done after writes, 3: done with no writes, 2: error
   logic [31:0] wbuf[64];
   logic [7:0]  tb_mem[MEMB];
   wr_t         mon_e;
   int          mon_ev;
   int          mon_act;

   imem_loader #(.MEM_BYTES(128), .ADDR_W(64), .CNT_W(6)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .base_addr  (base_addr),
      .word_count (word_count),
      .in_valid   (in_valid),
      .in_data    (in_data),
      .in_ready   (in_ready),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .busy       (busy),
      .done       (done),
      .error      (error)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] read32(input int unsigned a);
      return {tb_mem[a+3], tb_mem[a+2], tb_mem[a+1], tb_mem[a]};
   endfunction

   // Monitor: every write and every done/error pulse must match the scoreboard.
   always @(negedge clk) begin
      if (mon_en) begin
         if (mem_we) begin
            if (exp_q.size() == 0) begin
               total++; bad++;
               $display("FAIL unexp_write actual addr=0x%0h data=0x%0h required no write", mem_addr, mem_wdata);
            end else begin
               mon_e = exp_q.pop_front();
               check("wr_addr", mem_addr, mon_e.a);
               check("wr_data", 64'(mem_wdata), 64'(mon_e.d));
            end
            if (mem_addr < 64'(MEMB)) tb_mem[mem_addr[6:0]] = mem_wdata;
         end else begin
            check("wdata_idle", 64'(mem_wdata), 64'h0);
         end
         if (done || error) begin
            mon_act = {30'd0, error, done};
            if (ev_q.size() == 0) begin
               total++; bad++;
               $display("FAIL unexp_event actual done=%0d error=%0d required none", done, error);
            end else begin
               mon_ev = ev_q.pop_front();
               check("event_kind", 64'(mon_act), (mon_ev == 2) ? 64'd2 : 64'd1);
               if (mon_ev == 1) check("done_after_write", 64'(prev_we), 64'd1);
            end
         end
      end
      prev_we = mem_we;
   end

   // Reference model: legal loads produce 4*count ordered byte writes then done.
   task automatic expect_load(input logic [63:0] base, input int unsigned cnt, output bit ok);
      logic [31:0] sh;
      ok = (base[1:0] == 2'b00) && (base + 64'(4 * cnt) <= 64'(MEMB));
      if (ok) begin
         for (int w = 0; w < int'(cnt); w++)
            for (int b = 0; b < 4; b++) begin
               sh = wbuf[w] >> (8 * b);
               exp_q.push_back('{a: base + 64'(4 * w + b), d: sh[7:0]});
            end
         ev_q.push_back(cnt == 0 ? 3 : 1);
      end else begin
         ev_q.push_back(2);
      end
   endtask

   task automatic start_load(input logic [63:0] base, input int unsigned cnt);
      @(negedge clk);
      base_addr  = base;
      word_count = cnt[5:0];
      start      = 1'b1;
      @(negedge clk);
      start      = 1'b0;
   endtask

   task automatic send_word(input logic [31:0] w, input int unsigned gap);
      int unsigned t = 0;
      if (gap > 0) begin
         while (!in_ready && t < 64) begin @(negedge clk); t++; end
         repeat (gap) begin
            @(negedge clk);
            check("gap_ready", 64'(in_ready), 64'd1);
         end
      end
      in_valid = 1'b1;
      in_data  = w;
      t = 0;
      while (!in_ready && t < 64) begin @(negedge clk); t++; end
      check("ready_timeout", 64'(t < 64), 64'd1);
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int unsigned t = 0;
      while (busy && t < 200) begin @(negedge clk); t++; end
      check("idle_timeout", 64'(busy), 64'd0);
      check("sb_empty", 64'(exp_q.size()), 64'd0);
      check("ev_empty", 64'(ev_q.size()), 64'd0);
   endtask

   task automatic run_load(input logic [63:0] base, input int unsigned cnt,
                           input int unsigned gap, input bit poke);
      bit ok;
      expect_load(base, cnt, ok);
      start_load(base, cnt);
      if (ok) begin
         for (int w = 0; w < int'(cnt); w++) begin
            send_word(wbuf[w], (w == 0) ? 0 : gap);
            if (poke && w == 0) begin
               base_addr  = 64'd2;
               word_count = 6'd5;
               start      = 1'b1;
               @(negedge clk);
               start      = 1'b0;
            end
         end
      end
      wait_idle();
   endtask

   initial begin
      bit ok;
      int unsigned t;
      logic [63:0] rb;
      for (int i = 0; i < int'(MEMB); i++) tb_mem[i] = 8'h00;

      // reset state
      repeat (3) @(negedge clk);
      check("rst_outs", 64'({in_ready, mem_we, busy, done, error, mem_wdata}), 64'h0);
      check("rst_addr", mem_addr, 64'h0);
      rst_n  = 1'b1;
      mon_en = 1'b1;

      // single word with minimum latency (in_valid already high)
      wbuf[0] = 32'h8B1F03E5;
      expect_load(64'd0, 1, ok);
      @(negedge clk);
      base_addr = 64'd0; word_count = 6'd1; start = 1'b1;
      in_valid = 1'b1; in_data = wbuf[0];
      @(negedge clk);
      start = 1'b0;
      check("lat_check_we", 64'(mem_we), 64'd0);
      check("lat_check_rdy", 64'(in_ready), 64'd0);
      @(negedge clk);
      check("lat_wait_we", 64'(mem_we), 64'd0);
      check("lat_wait_rdy", 64'(in_ready), 64'd1);
      @(negedge clk);
      check("lat_first_we", 64'(mem_we), 64'd1);
      check("rdy_drop", 64'(in_ready), 64'd0);
      in_valid = 1'b0;
      wait_idle();
      check("single_read0", 64'(read32(0)), 64'h8B1F03E5);

      // four words, then memory read at 8
      wbuf[0] = 32'h8B1F03E5; wbuf[1] = 32'hF84000A4;
      wbuf[2] = 32'h8B040086; wbuf[3] = 32'hF80010A6;
      run_load(64'd0, 4, 0, 1'b0);
      check("mem_read8", 64'(read32(8)), 64'h8B040086);

      // backpressure gap of 3 cycles between words
      wbuf[0] = 32'h11223344; wbuf[1] = 32'hA5A5_5A5A; wbuf[2] = 32'hDEADBEEF;
      run_load(64'd32, 3, 3, 1'b0);
      check("bp_read40", 64'(read32(40)), 64'hDEADBEEF);

      // last legal word ends at 127
      wbuf[0] = 32'hCAFEF00D;
      run_load(64'd124, 1, 0, 1'b0);
      check("last_byte127", 64'(tb_mem[127]), 64'hCA);

      // bounds and alignment failures
      run_load(64'd124, 2, 0, 1'b0);
      run_load(64'd2, 1, 0, 1'b0);

      // zero length: done two cycles after start, no in_ready
      expect_load(64'd16, 0, ok);
      start_load(64'd16, 0);
      check("zl_done_early", 64'(done), 64'd0);
      check("zl_rdy1", 64'(in_ready), 64'd0);
      @(negedge clk);
      check("zl_done", 64'(done), 64'd1);
      check("zl_rdy2", 64'(in_ready), 64'd0);
      wait_idle();

      // start while busy is ignored
      wbuf[0] = 32'h01020304; wbuf[1] = 32'h05060708;
      run_load(64'd64, 2, 1, 1'b1);

      // reset during the second byte of a word
      wbuf[0] = 32'h99887766; wbuf[1] = 32'h55443322;
      expect_load(64'd0, 2, ok);
      @(negedge clk);
      base_addr = 64'd0; word_count = 6'd2; start = 1'b1;
      in_valid = 1'b1; in_data = wbuf[0];
      @(negedge clk);
      start = 1'b0;
      t = 0;
      while (!mem_we && t < 64) begin @(negedge clk); t++; end
      check("rst_wait_we", 64'(t < 64), 64'd1);
      @(negedge clk);
      rst_n = 1'b0;
      in_valid = 1'b0;
      @(negedge clk);
      check("midrst_outs", 64'({in_ready, mem_we, busy, done, error, mem_wdata}), 64'h0);
      check("midrst_addr", mem_addr, 64'h0);
      exp_q.delete();
      ev_q.delete();
      rst_n = 1'b1;
      repeat (6) @(negedge clk);
      check("midrst_idle", 64'(busy), 64'd0);

      // randomized loads
      for (int n = 0; n < 20; n++) begin
         rb = 64'($urandom_range(0, 135));
         if ($urandom_range(0, 3) != 0) rb[1:0] = 2'b00;
         t = $urandom_range(0, 9);
         for (int w = 0; w < 64; w++) wbuf[w] = $urandom();
         run_load(rb, t, $urandom_range(0, 3), 1'b0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

endmodule
